// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring unsigned divider, one quotient bit per clock.
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH:0] a_q, a_d, a_sh, t;
    logic [WIDTH-1:0] q_q, q_d, m_q, m_d, quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic done_q, done_d, dbz_q, dbz_d;
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        q_d = q_q;
        m_d = m_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        done_d = 1'b0;
        a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        t = a_sh - {1'b0, m_q};
        case (state_q)
            IDLE: if (start) begin
                m_d = divisor;
                q_d = dividend;
                a_d = '0;
                cnt_d = CW'(WIDTH);
                dbz_d = 1'b0;
                state_d = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                a_d = t[WIDTH] ? a_sh : t;
                q_d = {q_q[WIDTH-2:0], ~t[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? DONE : RUN;
            end
            DONE: begin
                // A zero divisor skips RUN, so Q still holds the dividend
                done_d = 1'b1;
                quo_d = (m_q == '0) ? '1 : q_q;
                rem_d = (m_q == '0) ? q_q : a_q[WIDTH-1:0];
                dbz_d = (m_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            q_q <= q_d;
            m_q <= m_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
            done_q <= done_d;
        end
    end
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign quotient = quo_q;
    assign remainder = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb_shift_sub_divider: scoreboard bench for the divider at WIDTH=8 and WIDTH=16.
module tb_shift_sub_divider;
    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st8 = 1'b0, busy8, done8, z8;
    logic [7:0] dd8 = '0, dv8 = '0, q8, r8;
    logic st16 = 1'b0, busy16, done16, z16;
    logic [15:0] dd16 = '0, dv16 = '0, q16, r16;
    exp_t exp8_q[$], exp16_q[$];
    int n_checks = 0, n_pass = 0, ndone8 = 0, cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    shift_sub_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .dividend(dd8), .divisor(dv8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );
    shift_sub_divider #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(st16), .dividend(dd16), .divisor(dv16),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask
    function automatic exp_t mk(input int sel, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [15:0] mask = sel != 0 ? 16'hFFFF : 16'h00FF;
        logic [15:0] aa = a & mask, bb = b & mask;
        e.q = (bb == 0) ? mask : aa / bb;
        e.r = (bb == 0) ? aa : aa % bb;
        e.z = (bb == 0);
        return e;
    endfunction
    always @(negedge clk) if (done8) begin
        exp_t e;
        ndone8++;
        check("sb8_entry", 32'(exp8_q.size() != 0), 1);
        if (exp8_q.size() != 0) begin
            e = exp8_q.pop_front();
            check("quo8", 32'(q8), 32'(e.q));
            check("rem8", 32'(r8), 32'(e.r));
            check("dbz8", 32'(z8), 32'(e.z));
        end
    end
    always @(negedge clk) if (done16) begin
        exp_t e;
        check("sb16_entry", 32'(exp16_q.size() != 0), 1);
        if (exp16_q.size() != 0) begin
            e = exp16_q.pop_front();
            check("quo16", 32'(q16), 32'(e.q));
            check("rem16", 32'(r16), 32'(e.r));
            check("dbz16", 32'(z16), 32'(e.z));
        end
    end
    // Waits for idle, presents one operation and returns just after the accepting edge
    task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b);
        int i;
        for (i = 0; i < 64 && (sel != 0 ? busy16 : busy8); i++) @(negedge clk);
        if (i == 64) check("idle_timeout", 1, 0);
        if (sel != 0) begin st16 = 1'b1; dd16 = a; dv16 = b; end
        else begin st8 = 1'b1; dd8 = a[7:0]; dv8 = b[7:0]; end
        @(posedge clk);
        if (sel != 0) exp16_q.push_back(mk(sel, a, b));
        else exp8_q.push_back(mk(sel, a, b));
        #1;
        st8 = 1'b0;
        st16 = 1'b0;
    endtask
    task automatic run(input int sel, input logic [15:0] a, input logic [15:0] b);
        int w = sel != 0 ? 16 : 8;
        int k;
        logic [15:0] bm = sel != 0 ? b : {8'h00, b[7:0]};
        issue(sel, a, b);
        for (k = 1; k <= w + 4; k++) begin
            @(posedge clk);
            #1;
            if (sel != 0 ? done16 : done8) break;
        end
        check("latency", 32'(k), (bm == 0) ? 1 : 32'(w + 1));
    endtask
    task automatic drain();
        for (int i = 0; i < 80 && (exp8_q.size() != 0 || exp16_q.size() != 0); i++) @(posedge clk);
        check("drain", 32'(exp8_q.size() + exp16_q.size()), 0);
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n, d0, acc[3];
        logic [15:0] a, b;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_quo", 32'(q8), 0);
        check("rst_rem", 32'(r8), 0);
        check("rst_dbz", 32'(z8), 0);
        @(negedge clk) rst = 1'b0;
        run(0, 100, 7);
        run(0, 255, 1);
        run(0, 5, 9);
        run(0, 0, 3);
        run(0, 77, 0);
        repeat (2) @(posedge clk);
        #1;
        check("dbz_held", 32'(z8), 1);
        check("dbz_quo_held", 32'(q8), 255);
        run(0, 9, 3);
        run(1, 16'hFFFF, 1);
        run(1, 1234, 0);
        run(1, 60000, 7);
        // Start pulses during RUN and DONE must be ignored
        d0 = ndone8;
        issue(0, 200, 13);
        repeat (3) @(posedge clk);
        #1;
        st8 = 1'b1; dd8 = 50; dv8 = 5;
        @(posedge clk);
        #1 st8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_in_done", 32'(busy8), 1);
        check("no_done_yet", 32'(done8), 0);
        st8 = 1'b1;
        @(posedge clk);
        #1 st8 = 1'b0;
        check("done_after_ign", 32'(done8), 1);
        repeat (3) @(posedge clk);
        #1;
        check("one_done", 32'(ndone8 - d0), 1);
        check("idle_after", 32'(busy8), 0);
        // Start held high: back-to-back accepts
        n = 0;
        st8 = 1'b1; dd8 = 200; dv8 = 13;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (!busy8) begin
                acc[n] = cyc + 1;
                exp8_q.push_back(mk(0, 200, 13));
                n++;
                if (n == 3) begin
                    @(posedge clk);
                    #1 st8 = 1'b0;
                end
            end
        end
        check("b2b_count", 32'(n), 3);
        check("b2b_gap1", 32'(acc[1] - acc[0]), 10);
        check("b2b_gap2", 32'(acc[2] - acc[1]), 10);
        drain();
        // Asynchronous reset in the middle of a division
        issue(0, 200, 13);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy8), 0);
        check("arst_done", 32'(done8), 0);
        check("arst_quo", 32'(q8), 0);
        check("arst_rem", 32'(r8), 0);
        check("arst_dbz", 32'(z8), 0);
        exp8_q.delete();
        @(negedge clk) rst = 1'b0;
        run(0, 200, 13);
        for (int i = 0; i < 3000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = 1;
                2: b = 16'h00FF;
                3: b = (a[7:0] == 8'hFF) ? 16'h00FF : {8'h00, a[7:0] + 8'd1};
                default: b = 16'($urandom);
            endcase
            issue(0, a, b);
        end
        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = 1;
                2: b = 16'hFFFF;
                3: b = (a == 16'hFFFF) ? a : a + 16'd1;
                default: b = 16'($urandom_range(0, 300));
            endcase
            issue(1, a, b);
        end
        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
